// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: sequencer states, default operand width
// and a sign-extension helper used by the multiplier and the divider.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Replicates bit w-1 of v into all higher bits (w in 1..64).
    function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
        logic [63:0] r_shl;
        r_shl = v << (64 - w);
        return 64'($signed(r_shl) >>> (64 - w));
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// Ripple-carry add/subtract cell: o_sum = i_a + i_b (mode 0) or i_a - i_b (mode 1),
// modulo 2^W, with subtraction done as i_a + ~i_b + 1.
module booth_addsub #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_mode,
    output logic [W-1:0] o_sum
);

    always_comb begin : ripple
        logic w_carry;
        logic w_bx;
        w_carry = i_mode;
        w_bx    = 1'b0;
        o_sum   = '0;
        for (int unsigned i = 0; i < W; i++) begin
            w_bx     = i_b[i] ^ i_mode;
            o_sum[i] = i_a[i] ^ w_bx ^ w_carry;
            w_carry  = (i_a[i] & w_bx) | (w_carry & (i_a[i] ^ w_bx));
        end
    end

endmodule

// File: rtl/booth_sequential_multiplier.sv
// Iterative signed radix-2 Booth multiplier: one Booth step per clock,
// 2N-bit product after N steps, start/done handshake.
module booth_sequential_multiplier
    import arith_pkg::*;
#(
    parameter int unsigned N = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           in_ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [N:0]      r_a;
    logic [N-1:0]    r_q;
    logic            r_qm1;
    logic [N:0]      r_m;
    logic [CW-1:0]   r_cnt;
    logic [2*N-1:0]  r_product;

    logic            w_accept;
    logic            w_step;
    logic            w_last;
    logic [N:0]      w_sum;
    logic [N:0]      w_a_sel;
    logic [N:0]      w_a_shift;
    logic [N-1:0]    w_q_shift;

    // Booth pair 10 subtracts, 01 adds; Qr[0] alone selects the mode.
    booth_addsub #(.W(N + 1)) u_addsub (
        .i_a    (r_a),
        .i_b    (r_m),
        .i_mode (r_q[0]),
        .o_sum  (w_sum)
    );

    always_comb begin
        w_a_sel   = (r_q[0] ^ r_qm1) ? w_sum : r_a;
        w_a_shift = {w_a_sel[N], w_a_sel[N:1]};
        w_q_shift = {w_a_sel[0], r_q[N-1:1]};
        w_last    = (r_cnt == LAST_STEP);
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_accept = start;
                if (start) w_next_state = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                in_ready     = 1'b1;
                done         = 1'b1;
                w_accept     = start;
                w_next_state = start ? RUN : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a   <= '0;
                r_q   <= multiplier;
                r_qm1 <= 1'b0;
                r_m   <= (N + 1)'(sext(64'(multiplicand), N));
                r_cnt <= '0;
            end else if (w_step) begin
                r_a   <= w_a_shift;
                r_q   <= w_q_shift;
                r_qm1 <= r_q[0];
                r_cnt <= r_cnt + CW'(1);
                // Product is captured on the final step so it is valid throughout DONE.
                if (w_last) r_product <= {w_a_shift[N-1:0], w_q_shift};
            end
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_sequential_multiplier.sv
// Directed and exhaustive checks of the N=4 Booth multiplier: latency,
// handshake, start-ignore, back-to-back, mid-run reset and all operand pairs.
module tb_booth_sequential_multiplier;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int errors = 0;
    int checks = 0;

    booth_sequential_multiplier #(.N(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .in_ready     (in_ready),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation from IDLE/DONE, then checks busy count, latency and product.
    task automatic do_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                         input string name);
        int n;
        int nbusy;
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        cycle();
        start = 1'b0;
        n     = 1;
        nbusy = 0;
        while (!done && n < 12) begin
            if (busy) nbusy++;
            cycle();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b required 1 within 12 cycles", name, done);
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL %s_latency: done after %0d cycles, required 5", name, n);
        end
        checks++;
        if (nbusy !== 4) begin
            errors++;
            $display("FAIL %s_busy: busy cycles=%0d required 4", name, nbusy);
        end
        checks++;
        if (product !== exp) begin
            errors++;
            $display("FAIL %s_product: M=%h Q=%h product=%h required %h", name, m, q, product, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        checks++;
        if ({in_ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: in_ready/busy/done=%b required 100", {in_ready, busy, done});
        end
        checks++;
        if (product !== 8'h00) begin
            errors++;
            $display("FAIL reset_product: product=%h required 00", product);
        end
    endtask

    task automatic test_directed();
        do_op(4'd3, 4'd5, 8'h0F, "m3_q5");
        cycle();
        checks++;
        if ({in_ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL after_done_idle: in_ready/busy/done=%b required 100", {in_ready, busy, done});
        end
        checks++;
        if (product !== 8'h0F) begin
            errors++;
            $display("FAIL product_hold_idle: product=%h required 0f", product);
        end
        do_op(4'h8, 4'h8, 8'h40, "mneg8_qneg8");
        cycle();
        do_op(4'h7, 4'h8, 8'hC8, "m7_qneg8");
        cycle();
        do_op(4'hF, 4'h1, 8'hFF, "mneg1_q1");
        cycle();
        do_op(4'h0, 4'h9, 8'h00, "m0_qneg7");
        cycle();
    endtask

    task automatic test_ignore_start();
        int n;
        start        = 1'b1;
        multiplicand = 4'd7;
        multiplier   = 4'd7;
        cycle();
        start = 1'b0;
        cycle();
        start        = 1'b1;
        multiplicand = 4'd2;
        multiplier   = 4'd2;
        checks++;
        if (product !== 8'h00) begin
            errors++;
            $display("FAIL product_hold_run: product=%h required 00", product);
        end
        cycle();
        cycle();
        start = 1'b0;
        n = 4;
        while (!done && n < 12) begin
            cycle();
            n++;
        end
        checks++;
        if (n !== 5 || done !== 1'b1) begin
            errors++;
            $display("FAIL ignore_latency: done=%b after %0d cycles, required 1 after 5", done, n);
        end
        checks++;
        if (product !== 8'h31) begin
            errors++;
            $display("FAIL ignore_product: product=%h required 31", product);
        end
        cycle();
        checks++;
        if ({in_ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL ignore_then_idle: in_ready/busy/done=%b required 100", {in_ready, busy, done});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start        = 1'b1;
        multiplicand = 4'd2;
        multiplier   = 4'd3;
        cycle();
        multiplicand = 4'hD;
        multiplier   = 4'd3;
        n = 1;
        while (!done && n < 12) begin
            cycle();
            n++;
        end
        checks++;
        if (n !== 5 || product !== 8'h06) begin
            errors++;
            $display("FAIL b2b_first: cycles=%0d product=%h required 5 and 06", n, product);
        end
        cycle();
        start = 1'b0;
        checks++;
        if ({in_ready, busy, done} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_reaccept: in_ready/busy/done=%b required 010", {in_ready, busy, done});
        end
        n = 1;
        while (!done && n < 12) begin
            cycle();
            n++;
        end
        checks++;
        if (n !== 5 || product !== 8'hF7) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d product=%h required 5 and f7", n, product);
        end
        cycle();
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        start        = 1'b1;
        multiplicand = 4'd3;
        multiplier   = 4'd5;
        cycle();
        start = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        checks++;
        if ({in_ready, busy, done} !== 3'b100 || product !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset: flags=%b product=%h required 100 and 00",
                     {in_ready, busy, done}, product);
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            cycle();
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: done pulses=%0d required 0", ndone);
        end
        do_op(4'd6, 4'hE, 8'hF4, "after_reset");
        cycle();
    endtask

    task automatic test_sweep();
        logic signed [3:0] sm;
        logic signed [3:0] sq;
        logic signed [7:0] ref_p;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                sm    = 4'(i);
                sq    = 4'(j);
                ref_p = sm * sq;
                do_op(sm, sq, ref_p, "sweep");
                repeat ($urandom_range(0, 3)) cycle();
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
